// File: rtl/io_controller.sv
// io_controller: memory-mapped UART handshake and cycle/instret counters for the 0x8000_0000 I/O region.
// Define IO_TX_FIFO_EN for a 4-entry TX FIFO; otherwise a single holding register buffers TX bytes.
module io_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  input  logic        instr_retire,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready
);

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_RX_DATA = 3'd1;
  localparam logic [2:0] REG_TX_DATA = 3'd2;
  localparam logic [2:0] REG_CYCLE   = 3'd4;
  localparam logic [2:0] REG_INSTR   = 3'd5;
  localparam logic [2:0] REG_CLEAR   = 3'd6;

  logic        io_sel;
  logic [2:0]  reg_off;
  logic        rd_en;
  logic        wr_en;
  logic        tx_push_req;
  logic        cnt_clear;
  logic        tx_space;
  logic        tx_push;
  logic        tx_pop;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  // Only the region bits and the word offset take part in decode; the rest alias.
  assign io_sel      = (io_addr[31:30] == 2'b10);
  assign reg_off     = io_addr[4:2];
  assign rd_en       = io_sel & io_re;
  assign wr_en       = io_sel & io_we;
  assign tx_push_req = wr_en & (reg_off == REG_TX_DATA);
  assign cnt_clear   = wr_en & (reg_off == REG_CLEAR);

  logic unused_bits;
  assign unused_bits = ^{io_addr[29:5], io_addr[1:0], io_wdata[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_clear) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end

`ifdef IO_TX_FIFO_EN
  logic [7:0] tx_mem [4];
  logic [1:0] tx_rd_ptr;
  logic [1:0] tx_wr_ptr;
  logic [2:0] tx_count;

  assign tx_space              = (tx_count != 3'd4);
  assign tx_push               = tx_push_req & tx_space;
  assign tx_pop                = (tx_count != 3'd0) & uart_tx_data_in_ready;
  assign uart_tx_data_in_valid = (tx_count != 3'd0);
  assign uart_tx_data_in       = tx_mem[tx_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the byte store is reset too, so uart_tx_data_in reads 0 out of reset.
      for (int i = 0; i < 4; i++) tx_mem[i] <= '0;
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= io_wdata[7:0];
        tx_wr_ptr         <= tx_wr_ptr + 2'd1;
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 2'd1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 3'd1;
        2'b01:   tx_count <= tx_count - 3'd1;
        default: tx_count <= tx_count;
      endcase
    end
  end
`else
  logic       tx_pend;
  logic [7:0] tx_data;

  assign tx_space              = ~tx_pend;
  assign tx_push               = tx_push_req & tx_space;
  assign tx_pop                = tx_pend & uart_tx_data_in_ready;
  assign uart_tx_data_in_valid = tx_pend;
  assign uart_tx_data_in       = tx_data;

  // Push needs an empty register and pop needs a full one, so they never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pend <= 1'b0;
      tx_data <= '0;
    end else if (tx_push) begin
      tx_pend <= 1'b1;
      tx_data <= io_wdata[7:0];
    end else if (tx_pop) begin
      tx_pend <= 1'b0;
    end
  end
`endif

  assign uart_rx_data_out_ready = rd_en & (reg_off == REG_RX_DATA);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    io_rdata = '0;
    if (rd_en) begin
      case (reg_off)
        REG_STATUS:  io_rdata = {30'b0, uart_rx_data_out_valid, tx_space};
        REG_RX_DATA: io_rdata = {24'b0, uart_rx_data_out};
        REG_CYCLE:   io_rdata = cycle_cnt;
        REG_INSTR:   io_rdata = instr_cnt;
        default:     io_rdata = '0;
      endcase
    end
  end

endmodule
